// File: rtl/rank_order_sorter_pkg.sv
// Shared definitions for the rank-order sorter: FSM encoding and small helpers
// used by the control path.
package rank_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Even phases compare (0,1),(2,3)..; odd phases compare (1,2),(3,4)..
  function automatic logic phase_is_odd(input int unsigned phase);
    return (phase % 2) == 1;
  endfunction

  // Ranks past the end of the window select the smallest element.
  function automatic int unsigned clamp_rank(input int unsigned rank,
                                             input int unsigned n);
    return (rank >= n) ? (n - 1) : rank;
  endfunction

endpackage

// File: rtl/rank_order_sorter_if.sv
// Request/result bundle between the line buffers and the rank-order sorter.
interface rank_order_sorter_if #(
  parameter int DATA_W = 8,
  parameter int N      = 9
);
  localparam int RANK_W = $clog2(N);

  logic                  start;
  logic [N*DATA_W-1:0]   window_in;
  logic [RANK_W-1:0]     rank_sel;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     value_out;
  logic [N*DATA_W-1:0]   sorted_out;

  modport master (
    output start, window_in, rank_sel,
    input  busy, done, value_out, sorted_out
  );

  modport slave (
    input  start, window_in, rank_sel,
    output busy, done, value_out, sorted_out
  );

endinterface

// File: rtl/rank_order_sorter_cmp_swap.sv
// Compare-exchange cell: larger value to the lower index, ties keep order.
module cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_swap
);

  assign o_swap = (i_b > i_a);
  assign o_hi   = o_swap ? i_b : i_a;
  assign o_lo   = o_swap ? i_a : i_b;

endmodule

// File: rtl/rank_order_sorter.sv
// Iterative odd-even transposition sorter: one network phase per clock,
// returns the element at a latched rank plus the full descending vector.
module rank_order_sorter
  import rank_sort_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int N          = 9,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  rank_order_sorter_if.slave  bus
);

  localparam int RANK_W = $clog2(N);
  localparam int PH_W   = $clog2(N + 1);
  localparam int NPAIR  = N / 2;

  typedef logic [N-1:0][DATA_W-1:0] vec_t;

  state_t             r_state;
  vec_t               r_arr;
  logic [PH_W-1:0]    r_phase;
  logic [RANK_W-1:0]  r_rank;
  logic [1:0]         r_swap_hist;
  logic               r_busy;
  logic               r_done;
  logic [DATA_W-1:0]  r_value;
  vec_t               r_sorted;

  vec_t               w_even_arr;
  vec_t               w_odd_arr;
  vec_t               w_next_arr;
  logic [NPAIR-1:0]   w_even_swap;
  logic [NPAIR-1:0]   w_odd_swap;
  logic               w_odd_phase;
  logic               w_any_swap;
  logic               w_last_phase;
  logic               w_early_exit;
  logic               w_exit;

  // The outermost element sits out of the even phase, the first of the odd one.
  assign w_even_arr[N-1] = r_arr[N-1];
  assign w_odd_arr[0]    = r_arr[0];

  for (genvar j = 0; j < NPAIR; j++) begin : g_pair
    cmp_swap #(.DATA_W(DATA_W)) u_even (
      .i_a    (r_arr[2*j]),
      .i_b    (r_arr[2*j+1]),
      .o_hi   (w_even_arr[2*j]),
      .o_lo   (w_even_arr[2*j+1]),
      .o_swap (w_even_swap[j])
    );

    cmp_swap #(.DATA_W(DATA_W)) u_odd (
      .i_a    (r_arr[2*j+1]),
      .i_b    (r_arr[2*j+2]),
      .o_hi   (w_odd_arr[2*j+1]),
      .o_lo   (w_odd_arr[2*j+2]),
      .o_swap (w_odd_swap[j])
    );
  end

  assign w_odd_phase  = phase_is_odd(32'(r_phase));
  assign w_next_arr   = w_odd_phase ? w_odd_arr : w_even_arr;
  assign w_any_swap   = w_odd_phase ? (|w_odd_swap) : (|w_even_swap);
  assign w_last_phase = (r_phase == PH_W'(N - 1));

  // hist[1] marks that a phase has already run, hist[0] whether it swapped;
  // two quiet phases in a row (one of each parity) mean the array is sorted.
  assign w_early_exit = EARLY_EXIT && r_swap_hist[1] && !r_swap_hist[0] && !w_any_swap;
  assign w_exit       = w_last_phase || w_early_exit;

  // NOTE: every register here is written with <= so all reads in this block
  // see the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      // NOTE: the working array and result registers are explicitly cleared
      // because outputs must read zero after reset, not just the control path.
      r_arr       <= '0;
      r_phase     <= '0;
      r_rank      <= '0;
      r_swap_hist <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_value     <= '0;
      r_sorted    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_arr       <= vec_t'(bus.window_in);
            r_rank      <= RANK_W'(clamp_rank(32'(bus.rank_sel), N));
            r_phase     <= '0;
            r_swap_hist <= '0;
            r_state     <= ST_SORT;
            r_busy      <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end
        end

        ST_SORT: begin
          r_arr       <= w_next_arr;
          r_phase     <= r_phase + 1'b1;
          r_swap_hist <= {1'b1, w_any_swap};
          if (w_exit) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_value  <= w_next_arr[r_rank];
            r_sorted <= w_next_arr;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.value_out  = r_value;
  assign bus.sorted_out = r_sorted;

endmodule

// File: tb/tb_rank_order_sorter.sv
// Directed and random checks of the rank-order sorter in four configurations,
// with a scoreboard of software-sorted expectations popped on each done pulse.
module tb_rank_order_sorter;

  typedef struct packed {
    logic [11:0]  value;
    logic [299:0] sorted;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   start_v = '0;
  logic [71:0]  win9    = '0;
  logic [3:0]   rank9   = '0;
  logic [299:0] win25   = '0;
  logic [4:0]   rank25  = '0;

  logic [3:0]   done_v;
  logic [3:0]   busy_v;
  logic [11:0]  val_v    [4];
  logic [299:0] sorted_v [4];

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t q_d[$];

  rank_order_sorter_if #(.DATA_W(8),  .N(9))  if_a ();
  rank_order_sorter_if #(.DATA_W(8),  .N(9))  if_b ();
  rank_order_sorter_if #(.DATA_W(12), .N(25)) if_c ();
  rank_order_sorter_if #(.DATA_W(12), .N(25)) if_d ();

  rank_order_sorter #(.DATA_W(8),  .N(9),  .EARLY_EXIT(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  rank_order_sorter #(.DATA_W(8),  .N(9),  .EARLY_EXIT(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  rank_order_sorter #(.DATA_W(12), .N(25), .EARLY_EXIT(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  rank_order_sorter #(.DATA_W(12), .N(25), .EARLY_EXIT(1'b1)) u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  assign if_a.start = start_v[0];  assign if_a.window_in = win9;   assign if_a.rank_sel = rank9;
  assign if_b.start = start_v[1];  assign if_b.window_in = win9;   assign if_b.rank_sel = rank9;
  assign if_c.start = start_v[2];  assign if_c.window_in = win25;  assign if_c.rank_sel = rank25;
  assign if_d.start = start_v[3];  assign if_d.window_in = win25;  assign if_d.rank_sel = rank25;

  assign done_v = {if_d.done, if_c.done, if_b.done, if_a.done};
  assign busy_v = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign val_v[0] = {4'b0, if_a.value_out};
  assign val_v[1] = {4'b0, if_b.value_out};
  assign val_v[2] = if_c.value_out;
  assign val_v[3] = if_d.value_out;
  assign sorted_v[0] = {228'b0, if_a.sorted_out};
  assign sorted_v[1] = {228'b0, if_b.sorted_out};
  assign sorted_v[2] = if_c.sorted_out;
  assign sorted_v[3] = if_d.sorted_out;

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Software reference: plain descending sort, then clamp and select the rank.
  function automatic exp_t model(input logic [299:0] win, input int n, input int w, input int rank);
    int unsigned e[25];
    int unsigned t;
    int          rk;
    exp_t        r;
    for (int i = 0; i < 25; i++) e[i] = 0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < w; b++) e[i][b] = win[i*w + b];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (e[j] < e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < w; b++) r.sorted[i*w + b] = e[i][b];
    rk = (rank >= n) ? n - 1 : rank;
    r.value = 12'(e[rk]);
    return r;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      2:       q_c.push_back(e);
      default: q_d.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
      1:       if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
      2:       if (q_c.size() > 0) begin e = q_c.pop_front(); ok = 1'b1; end
      default: if (q_d.size() > 0) begin e = q_d.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic launch(input int d, input logic [299:0] win, input int rank,
                        input bit expect_out, input bit hold);
    if (d < 2) begin
      win9  = win[71:0];
      rank9 = 4'(rank);
    end else begin
      win25  = win;
      rank25 = 5'(rank);
    end
    start_v[d] = 1'b1;
    if (expect_out) push_exp(d, model(win, (d < 2) ? 9 : 25, (d < 2) ? 8 : 12, rank));
    @(posedge clk);
    #1;
    if (!hold) start_v[d] = 1'b0;
  endtask

  // Latency in edges from the accepting edge to the edge that first samples
  // done high; -1 if done never arrives within the budget.
  task automatic wait_done(input int d, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (!busy_v[d]) busy_ok = 1'b0;
      if (done_v[d]) begin
        lat = j + 1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        if (done_v[d]) begin
          bit   ok;
          exp_t e;
          pop_exp(d, ok, e);
          check($sformatf("sb_pending_%0d", d), 300'(ok), 300'(1));
          if (ok) begin
            check($sformatf("sb_value_%0d", d), 300'(val_v[d]), 300'(e.value));
            check($sformatf("sb_sorted_%0d", d), sorted_v[d], e.sorted);
          end
        end
      end
    end
  end

  initial begin
    logic [299:0] w;
    int           lat, lat_b, lat_c, lat_d;
    bit           bok, bok_b, bok_c, bok_d;
    int           n_extra;
    int           rk;

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_busy_%0d", d),   300'(busy_v[d]), 300'(0));
      check($sformatf("rst_done_%0d", d),   300'(done_v[d]), 300'(0));
      check($sformatf("rst_value_%0d", d),  300'(val_v[d]),  300'(0));
      check($sformatf("rst_sorted_%0d", d), sorted_v[d],     300'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Ascending 1..9, median rank: fixed latency and busy through SORT/DONE
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(i + 1);
    launch(0, w, 4, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t1_latency", 300'(lat), 300'(10));
    check("t1_busy_span", 300'(bok), 300'(1));
    check("t1_value", 300'(val_v[0]), 300'(5));
    @(negedge clk);
    check("t1_idle_busy", 300'(busy_v[0]), 300'(0));
    check("t1_idle_done", 300'(done_v[0]), 300'(0));

    // Max, min and an out-of-range rank that clamps to min
    launch(0, w, 0, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t2_max", 300'(val_v[0]), 300'(9));
    @(negedge clk);
    launch(0, w, 8, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t2_min", 300'(val_v[0]), 300'(1));
    @(negedge clk);
    launch(0, w, 12, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t2_clamp", 300'(val_v[0]), 300'(1));
    @(negedge clk);

    // All-equal window on both N=9 variants at once
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'h7F;
    win9  = w[71:0];
    rank9 = 4'd4;
    start_v[1:0] = 2'b11;
    push_exp(0, model(w, 9, 8, 4));
    push_exp(1, model(w, 9, 8, 4));
    @(posedge clk);
    #1;
    start_v[1:0] = 2'b00;
    fork
      wait_done(0, lat, bok);
      wait_done(1, lat_b, bok_b);
    join
    check("t3_lat_full", 300'(lat), 300'(10));
    check("t3_lat_early", 300'(lat_b), 300'(3));
    check("t3_value_early", 300'(val_v[1]), 300'(8'h7F));
    repeat (2) @(negedge clk);

    // start held high through SORT: exactly one done
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'((i * 37 + 11) % 256);
    launch(0, w, 3, 1'b1, 1'b1);
    fork
      wait_done(0, lat, bok);
      begin
        repeat (5) @(posedge clk);
        #1;
        start_v[0] = 1'b0;
      end
    join
    check("t4_held_latency", 300'(lat), 300'(10));
    n_extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_v[0]) n_extra++;
    end
    check("t4_single_done", 300'(n_extra), 300'(0));

    // Back-to-back: new request accepted in the DONE cycle
    launch(0, w, 6, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t4_b2b_first", 300'(lat), 300'(10));
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'((i * 91 + 200) % 256);
    launch(0, w, 2, 1'b1, 1'b0);
    wait_done(0, lat, bok);
    check("t4_b2b_second", 300'(lat), 300'(10));
    check("t4_b2b_busy", 300'(bok), 300'(1));
    @(negedge clk);

    // Reset in the middle of a sort aborts it silently
    launch(0, w, 4, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy", 300'(busy_v[0]), 300'(0));
    check("t5_done", 300'(done_v[0]), 300'(0));
    check("t5_value", 300'(val_v[0]), 300'(0));
    check("t5_sorted", sorted_v[0], 300'(0));
    @(negedge clk);
    rst = 1'b0;
    n_extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) n_extra++;
    end
    check("t5_no_done", 300'(n_extra), 300'(0));

    // Random 25x12 windows on both EARLY_EXIT settings
    for (int it = 0; it < 1000; it++) begin
      w = '0;
      for (int i = 0; i < 25; i++) w[i*12 +: 12] = 12'($urandom_range(0, 4095));
      if (it % 8 == 3)
        for (int i = 0; i < 25; i++) w[i*12 +: 12] = 12'(100 + (i % 3));
      rk = (it % 4 == 0) ? 12 : int'($urandom_range(0, 31));
      win25  = w;
      rank25 = 5'(rk);
      start_v[3:2] = 2'b11;
      push_exp(2, model(w, 25, 12, rk));
      push_exp(3, model(w, 25, 12, rk));
      @(posedge clk);
      #1;
      start_v[3:2] = 2'b00;
      fork
        wait_done(2, lat_c, bok_c);
        wait_done(3, lat_d, bok_d);
      join
      check("t6_lat_full", 300'(lat_c), 300'(26));
      check("t6_lat_early", 300'(lat_d >= 3 && lat_d <= 26), 300'(1));
      repeat (2) @(negedge clk);
    end

    check("sb_drained_a", 300'(q_a.size()), 300'(0));
    check("sb_drained_b", 300'(q_b.size()), 300'(0));
    check("sb_drained_c", 300'(q_c.size()), 300'(0));
    check("sb_drained_d", 300'(q_d.size()), 300'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
